// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared constants and fill-state encoding for the serial
//             pattern detector.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Default geometry of the detector
  localparam int                       c_DEF_PAT_W     = 3;
  localparam int                       c_DEF_CNT_W     = 8;
  localparam logic [c_DEF_PAT_W-1:0]   c_DEF_RESET_PAT = 3'b101;

  // The fill counter doubles as the state: FILL until PAT_W bits are held
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_shift_match.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_match
//  Brief    : History shift register, saturating fill counter (the FSM) and
//             window comparator for the serial pattern detector.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_shift_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = c_DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,    // x qualifies this cycle
  input  logic             i_x,        // serial bit
  input  logic             i_load,     // pattern load: restart fill, drop x
  input  logic             i_restart,  // non-overlap match: restart fill
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_match,    // combinational match this cycle
  output logic             o_armed     // registered fill==PAT_W
);

  localparam int                  c_FILL_W = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FULL   = c_FILL_W'(PAT_W);
  localparam logic [c_FILL_W-1:0] c_NEAR   = c_FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]    r_hist;
  logic [PAT_W-1:0]    w_hist_nxt;
  logic [PAT_W-1:0]    w_window;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_FILL_W-1:0] w_fill_nxt;
  logic                r_armed;
  logic                w_armed_nxt;
  fill_state_e         w_state_nxt;
  logic                w_unused_hist_msb;

  // Window as it would look with the current bit shifted in
  assign w_window = {r_hist[PAT_W-2:0], i_x};

  // The oldest history bit falls out of every window; kept for visibility only
  assign w_unused_hist_msb = r_hist[PAT_W-1];

  // A load cycle discards x, so no match can be evaluated in it
  assign o_match = i_valid && !i_load && (w_window == i_pattern) && (r_fill >= c_NEAR);

  // State register: history, fill counter and armed flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // Next-state: load beats valid; a restart clears fill but history still shifts
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (i_load) begin
      w_fill_nxt = '0;
    end else if (i_valid) begin
      w_hist_nxt = w_window;
      if (i_restart) begin
        w_fill_nxt = '0;
      end else if (r_fill != c_FULL) begin
        w_fill_nxt = r_fill + c_FILL_W'(1);
      end
    end
  end

  // Output decode: armed follows the state the fill counter is entering
  always_comb begin
    w_state_nxt = (w_fill_nxt == c_FULL) ? ST_ARMED : ST_FILL;
    w_armed_nxt = (w_state_nxt == ST_ARMED);
  end

  assign o_armed = r_armed;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_detector
//  Brief    : Serial bit-pattern detector with loadable pattern, optional
//             overlapping matches, registered match pulse and saturating
//             match counter.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = c_DEF_PAT_W,
  parameter int               CNT_W     = c_DEF_CNT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(c_DEF_RESET_PAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [PAT_W-1:0] r_pattern;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;
  logic             w_match;
  logic             w_restart;

  // overlap only matters in the cycle that actually matches
  assign w_restart = w_match & ~overlap;

  seq_shift_match #(
    .PAT_W (PAT_W)
  ) u_shift_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (x_valid),
    .i_x       (x),
    .i_load    (pat_load),
    .i_restart (w_restart),
    .i_pattern (r_pattern),
    .o_match   (w_match),
    .o_armed   (armed)
  );

  // Pattern register: reloaded by the strobe, reset to the build-time pattern
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pattern <= RESET_PAT;
    end else if (pat_load) begin
      r_pattern <= pat_in;
    end
  end

  // Match pulse and saturating counter update on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_z <= w_match;
      if (w_match && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign z         = r_z;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_detector
//  Brief    : Self-checking bench; three detector builds (3-bit, 4-bit and
//             2-bit counter) share one stimulus and a window-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n, x, x_valid, overlap, pat_load;
  logic [3:0] pat_in;

  logic       z_a, z_b, z_c, armed_a, armed_b, armed_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(3), .CNT_W(8), .RESET_PAT(3'b101)) u_a (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in[2:0]), .z(z_a), .match_cnt(cnt_a), .armed(armed_a));

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .RESET_PAT(4'b0101)) u_b (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_b), .match_cnt(cnt_b), .armed(armed_b));

  seq_pattern_detector #(.PAT_W(3), .CNT_W(2), .RESET_PAT(3'b101)) u_c (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in[2:0]), .z(z_c), .match_cnt(cnt_c), .armed(armed_c));

  // Model: last PAT_W received bits vs pattern, with a count of bits since restart
  int pw[3]   = '{3, 4, 3};
  int cmax[3] = '{255, 255, 3};
  int rpat[3] = '{5, 5, 5};
  int m_hist[3], m_pat[3], m_since[3], m_cnt[3];
  bit m_z[3], m_armed[3];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [31:0] za, zb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int mask;
      int win;
      bit hit;
      mask = (1 << pw[i]) - 1;
      if (!rst_n) begin
        m_hist[i] = 0; m_since[i] = 0; m_pat[i] = rpat[i]; m_z[i] = 0; m_cnt[i] = 0;
      end else if (pat_load) begin
        m_pat[i] = int'(pat_in) & mask; m_since[i] = 0; m_z[i] = 0;
      end else if (x_valid) begin
        win = ((m_hist[i] << 1) | int'(x)) & mask;
        hit = (m_since[i] + 1 >= pw[i]) && (win == m_pat[i]);
        m_hist[i] = win;
        m_z[i] = hit;
        if (hit && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (hit && !overlap) m_since[i] = 0;
        else if (m_since[i] < pw[i]) m_since[i]++;
      end else begin
        m_z[i] = 0;
      end
      m_armed[i] = (m_since[i] == pw[i]);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, return on negedge
  task automatic cyc(input bit v, input bit xb, input bit ld, input logic [3:0] pin, input bit rn);
    rst_n = rn; x_valid = v; x = xb; pat_load = ld; pat_in = pin;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step_cap(input bit v, input bit xb, input bit ld, input logic [3:0] pin);
    cyc(v, xb, ld, pin, 1'b1);
    za = {za[30:0], z_a};
    zb = {zb[30:0], z_b};
  endtask

  task automatic send(input int n, input logic [31:0] seq);
    for (int k = n - 1; k >= 0; k--) step_cap(1'b1, seq[k], 1'b0, 4'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    za = '0;
    zb = '0;
  endtask

  // Every-cycle comparison of all three builds against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("z_a", z_a, m_z[0]);         check("cnt_a", cnt_a, m_cnt[0]);   check("armed_a", armed_a, m_armed[0]);
      check("z_b", z_b, m_z[1]);         check("cnt_b", cnt_b, m_cnt[1]);   check("armed_b", armed_b, m_armed[1]);
      check("z_c", z_c, m_z[2]);         check("cnt_c", cnt_c, m_cnt[2]);   check("armed_c", armed_c, m_armed[2]);
    end
  end

  initial begin
    rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = 4'b0;
    za = '0; zb = '0;
    do_reset();
    chk_en = 1'b1;
    check("reset_z", z_a, 0);
    check("reset_cnt", cnt_a, 0);
    check("reset_armed", armed_a, 0);

    // Basic 101 detection and single-cycle pulse
    overlap = 1'b1;
    send(3, 3'b101);
    check("basic_zseq", za[2:0], 3'b001);
    check("basic_cnt", cnt_a, 1);
    check("basic_armed", armed_a, 1);
    step_cap(1'b0, 1'b0, 1'b0, 4'b0);
    check("basic_z_one_cycle", z_a, 0);

    // Overlapping vs restarting search on 10101
    do_reset();
    send(5, 5'b10101);
    check("ovl_zseq", za[4:0], 5'b00101);
    check("ovl_cnt", cnt_a, 2);
    overlap = 1'b0;
    do_reset();
    send(5, 5'b10101);
    check("novl_zseq", za[4:0], 5'b00100);
    check("novl_cnt", cnt_a, 1);

    // Idle cycles are ignored and keep z low
    overlap = 1'b1;
    do_reset();
    send(2, 2'b10);
    for (int k = 0; k < 3; k++) step_cap(1'b0, 1'b1, 1'b0, 4'b0);
    send(1, 1'b1);
    check("idle_zseq", za[5:0], 6'b000001);

    // 4-bit build: load beats valid, then only the new pattern matches
    do_reset();
    step_cap(1'b1, 1'b1, 1'b1, 4'b1100);
    send(7, 7'b1001100);
    check("load_zseq_b", zb[7:0], 8'b00000001);
    check("load_cnt_b", cnt_b, 1);
    zb = '0;
    send(3, 3'b101);
    check("load_101_zseq_b", zb[2:0], 3'b000);
    check("load_101_cnt_b", cnt_b, 1);

    // Counter saturation on the 2-bit build
    do_reset();
    send(11, 11'b10101010101);
    check("sat_cnt_c", cnt_c, 3);
    check("sat_cnt_a", cnt_a, 5);

    // Reset mid-pattern loses the partial match
    send(2, 2'b10);
    cyc(1'b1, 1'b1, 1'b1, 4'b0011, 1'b0);
    check("midrst_z", z_a, 0);
    check("midrst_cnt", cnt_a, 0);
    check("midrst_armed", armed_a, 0);
    za = '0;
    send(1, 1'b1);
    check("midrst_single", za[0], 0);
    send(3, 3'b101);
    check("midrst_zseq", za[2:0], 3'b001);
    check("midrst_cnt_after", cnt_a, 1);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      overlap = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 199) != 0));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
